mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 12 +
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_INSTR = 2'd1,
      ARB_DATA  = 2'd2
   } arb_state_t;

   localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single combinational-read memory.
// Optional starvation guard for the instruction port: MEM_ARB_STARVE_GUARD_EN.
//
// state     | meaning
// ARB_IDLE  | no grant last cycle, no response this cycle
// ARB_INSTR | instruction granted last cycle, if_resp_valid this cycle
// ARB_DATA  | data granted last cycle, dm_resp_valid this cycle
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH   = 12,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clock,
   input  logic                  reset,

   input  logic                  if_req_valid,
   output logic                  if_req_ready,
   input  logic [ADDR_WIDTH-1:0] if_req_addr,
   output logic                  if_resp_valid,
   output logic [DATA_WIDTH-1:0] if_resp_data,

   input  logic                  dm_req_valid,
   output logic                  dm_req_ready,
   input  logic                  dm_req_write,
   input  logic [3:0]            dm_req_be,
   input  logic [ADDR_WIDTH-1:0] dm_req_addr,
   input  logic [DATA_WIDTH-1:0] dm_req_wdata,
   output logic                  dm_resp_valid,
   output logic [DATA_WIDTH-1:0] dm_resp_data,

   output logic                  mem_enable,
   output logic                  mem_write_enable,
   output logic [3:0]            mem_byte_enable,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   input  logic [DATA_WIDTH-1:0] mem_read_data
);

   arb_state_t state, state_next;
   logic       grant_if;
   logic       grant_dm;
   logic       starve_hit;

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] starve_cnt;

   assign starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));

   // Saturating count of data wins while the instruction port is kept waiting.
   always_ff @(posedge clock) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (!if_req_valid || grant_if) begin
         starve_cnt <= '0;
      end else if (grant_dm && !starve_hit) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end
`else
   // The limit only matters when the guard is built.
   logic unused_starve_limit;
   assign unused_starve_limit = ^STARVE_LIMIT;
   assign starve_hit          = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ARB_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      grant_if         = 1'b0;
      grant_dm         = 1'b0;
      state_next       = ARB_IDLE;
      mem_enable       = 1'b0;
      mem_write_enable = 1'b0;
      mem_byte_enable  = 4'h0;
      mem_address      = '0;
      mem_write_data   = '0;

      if (!reset) begin
         if (dm_req_valid && !(if_req_valid && starve_hit)) begin
            grant_dm = 1'b1;
         end else if (if_req_valid) begin
            grant_if = 1'b1;
         end
      end

      if (grant_dm) begin
         state_next       = ARB_DATA;
         mem_enable       = 1'b1;
         mem_write_enable = dm_req_write;
         mem_byte_enable  = dm_req_be;
         mem_address      = dm_req_addr;
         mem_write_data   = dm_req_wdata;
      end else if (grant_if) begin
         state_next       = ARB_INSTR;
         mem_enable       = 1'b1;
         mem_byte_enable  = BE_FULL;
         mem_address      = if_req_addr;
      end
   end

   assign if_req_ready = grant_if;
   assign dm_req_ready = grant_dm;

   // Writes acknowledge with zero data; each port holds its last response otherwise.
   always_ff @(posedge clock) begin
      if (reset) begin
         if_resp_data <= '0;
         dm_resp_data <= '0;
      end else begin
         if (grant_if) begin
            if_resp_data <= mem_read_data;
         end
         if (grant_dm) begin
            dm_resp_data <= dm_req_write ? '0 : mem_read_data;
         end
      end
   end

   assign if_resp_valid = (state == ARB_INSTR);
   assign dm_resp_valid = (state == ARB_DATA);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a byte-enabled memory model.
// Starvation expectations follow MEM_ARB_STARVE_GUARD_EN.
module tb_mem_arbiter;

   logic        clock;
   logic        reset;
   logic        if_req_valid;
   logic        if_req_ready;
   logic [11:0] if_req_addr;
   logic        if_resp_valid;
   logic [31:0] if_resp_data;
   logic        dm_req_valid;
   logic        dm_req_ready;
   logic        dm_req_write;
   logic [3:0]  dm_req_be;
   logic [11:0] dm_req_addr;
   logic [31:0] dm_req_wdata;
   logic        dm_resp_valid;
   logic [31:0] dm_resp_data;
   logic        mem_enable;
   logic        mem_write_enable;
   logic [3:0]  mem_byte_enable;
   logic [11:0] mem_address;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   int n_tests = 0;
   int n_fail  = 0;
   int n_if    = 0;
   int exp_if_grants;

   logic [31:0] mem [0:1023];
   logic        unused_addr_lsb;

   mem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
      .clock            (clock),
      .reset            (reset),
      .if_req_valid     (if_req_valid),
      .if_req_ready     (if_req_ready),
      .if_req_addr      (if_req_addr),
      .if_resp_valid    (if_resp_valid),
      .if_resp_data     (if_resp_data),
      .dm_req_valid     (dm_req_valid),
      .dm_req_ready     (dm_req_ready),
      .dm_req_write     (dm_req_write),
      .dm_req_be        (dm_req_be),
      .dm_req_addr      (dm_req_addr),
      .dm_req_wdata     (dm_req_wdata),
      .dm_resp_valid    (dm_resp_valid),
      .dm_resp_data     (dm_resp_data),
      .mem_enable       (mem_enable),
      .mem_write_enable (mem_write_enable),
      .mem_byte_enable  (mem_byte_enable),
      .mem_address      (mem_address),
      .mem_write_data   (mem_write_data),
      .mem_read_data    (mem_read_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   assign mem_read_data   = mem[mem_address[11:2]];
   assign unused_addr_lsb = ^mem_address[1:0];

   always @(posedge clock) begin
      if (mem_enable && mem_write_enable) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_byte_enable[b]) mem[mem_address[11:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset        = 1'b1;
      if_req_valid = 1'b0;
      if_req_addr  = 12'h000;
      dm_req_valid = 1'b0;
      dm_req_write = 1'b0;
      dm_req_be    = 4'h0;
      dm_req_addr  = 12'h000;
      dm_req_wdata = 32'h0;

      // Reset: requests present but everything must stay quiet.
      step();
      step();
      if_req_valid = 1'b1;
      dm_req_valid = 1'b1;
      #1;
      chk("rst_if_ready", {31'd0, if_req_ready}, 32'd0);
      chk("rst_dm_ready", {31'd0, dm_req_ready}, 32'd0);
      chk("rst_mem_en", {31'd0, mem_enable}, 32'd0);
      chk("rst_mem_addr", {20'd0, mem_address}, 32'd0);
      chk("rst_if_rvalid", {31'd0, if_resp_valid}, 32'd0);
      chk("rst_dm_rvalid", {31'd0, dm_resp_valid}, 32'd0);
      chk("rst_if_rdata", if_resp_data, 32'd0);
      chk("rst_dm_rdata", dm_resp_data, 32'd0);
      if_req_valid = 1'b0;
      dm_req_valid = 1'b0;
      reset        = 1'b0;
      step();

      // Preload 0x010 with DEADBEEF and clear 0x020 through the data port.
      dm_req_valid = 1'b1;
      dm_req_write = 1'b1;
      dm_req_be    = 4'hF;
      dm_req_addr  = 12'h010;
      dm_req_wdata = 32'hDEADBEEF;
      #1;
      chk("wr_dm_ready", {31'd0, dm_req_ready}, 32'd1);
      chk("wr_mem_we", {31'd0, mem_write_enable}, 32'd1);
      chk("wr_mem_addr", {20'd0, mem_address}, 32'h010);
      chk("wr_mem_wdata", mem_write_data, 32'hDEADBEEF);
      step();
      chk("wr_ack_valid", {31'd0, dm_resp_valid}, 32'd1);
      chk("wr_ack_data", dm_resp_data, 32'd0);
      dm_req_addr  = 12'h020;
      dm_req_wdata = 32'h0;
      step();
      dm_req_valid = 1'b0;
      dm_req_write = 1'b0;

      // Lone instruction read.
      if_req_valid = 1'b1;
      if_req_addr  = 12'h010;
      #1;
      chk("if_ready", {31'd0, if_req_ready}, 32'd1);
      chk("if_dm_ready", {31'd0, dm_req_ready}, 32'd0);
      chk("if_mem_be", {28'd0, mem_byte_enable}, 32'hF);
      chk("if_mem_we", {31'd0, mem_write_enable}, 32'd0);
      step();
      if_req_valid = 1'b0;
      chk("if_rvalid", {31'd0, if_resp_valid}, 32'd1);
      chk("if_rdata", if_resp_data, 32'hDEADBEEF);
      chk("if_no_dm_rvalid", {31'd0, dm_resp_valid}, 32'd0);

      // Partial write over the cleared word, then read it back.
      dm_req_valid = 1'b1;
      dm_req_write = 1'b1;
      dm_req_be    = 4'b0011;
      dm_req_addr  = 12'h020;
      dm_req_wdata = 32'h11223344;
      #1;
      chk("pw_mem_be", {28'd0, mem_byte_enable}, 32'h3);
      step();
      chk("pw_ack_valid", {31'd0, dm_resp_valid}, 32'd1);
      chk("pw_ack_data", dm_resp_data, 32'd0);
      dm_req_write = 1'b0;
      step();
      dm_req_valid = 1'b0;
      chk("rd_rvalid", {31'd0, dm_resp_valid}, 32'd1);
      chk("rd_rdata", dm_resp_data, 32'h00003344);
      chk("if_rdata_hold", if_resp_data, 32'hDEADBEEF);
      chk("rd_no_if_rvalid", {31'd0, if_resp_valid}, 32'd0);

      // Contention for one cycle: data wins, instruction follows.
      step();
      if_req_valid = 1'b1;
      if_req_addr  = 12'h010;
      dm_req_valid = 1'b1;
      #1;
      chk("ct_dm_ready", {31'd0, dm_req_ready}, 32'd1);
      chk("ct_if_ready", {31'd0, if_req_ready}, 32'd0);
      chk("ct_mem_addr", {20'd0, mem_address}, 32'h020);
      step();
      dm_req_valid = 1'b0;
      #1;
      chk("ct2_if_ready", {31'd0, if_req_ready}, 32'd1);
      chk("ct2_mem_addr", {20'd0, mem_address}, 32'h010);
      chk("ct2_dm_rvalid", {31'd0, dm_resp_valid}, 32'd1);
      chk("ct2_dm_rdata", dm_resp_data, 32'h00003344);
      chk("ct2_if_rvalid", {31'd0, if_resp_valid}, 32'd0);
      step();
      if_req_valid = 1'b0;
      chk("ct3_if_rvalid", {31'd0, if_resp_valid}, 32'd1);
      chk("ct3_if_rdata", if_resp_data, 32'hDEADBEEF);
      chk("ct3_dm_rvalid", {31'd0, dm_resp_valid}, 32'd0);
      step();

      // Both ports valid continuously for 20 cycles.
      if_req_valid = 1'b1;
      dm_req_valid = 1'b1;
      n_if = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
`ifdef MEM_ARB_STARVE_GUARD_EN
         chk($sformatf("starve_if_ready_%0d", i), {31'd0, if_req_ready}, ((i % 5) == 4) ? 32'd1 : 32'd0);
`else
         chk($sformatf("starve_if_ready_%0d", i), {31'd0, if_req_ready}, 32'd0);
`endif
         if (if_req_ready) n_if++;
         step();
      end
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_if_grants = 4;
`else
      exp_if_grants = 0;
`endif
      chk("starve_if_grants", n_if, exp_if_grants);

      // Reset arriving in a data grant cycle drops the pending response.
      if_req_valid = 1'b0;
      dm_req_valid = 1'b1;
      dm_req_addr  = 12'h020;
      #1;
      chk("mr_dm_ready", {31'd0, dm_req_ready}, 32'd1);
      reset = 1'b1;
      #1;
      chk("mr_dm_ready_rst", {31'd0, dm_req_ready}, 32'd0);
      chk("mr_mem_en_rst", {31'd0, mem_enable}, 32'd0);
      step();
      chk("mr_dm_rvalid", {31'd0, dm_resp_valid}, 32'd0);
      chk("mr_if_rvalid", {31'd0, if_resp_valid}, 32'd0);
      chk("mr_dm_rdata", dm_resp_data, 32'd0);
      chk("mr_if_rdata", if_resp_data, 32'd0);
      chk("mr_mem_addr", {20'd0, mem_address}, 32'd0);
      step();
      reset        = 1'b0;
      dm_req_valid = 1'b0;
      step();
      chk("mr_post_dm_rvalid", {31'd0, dm_resp_valid}, 32'd0);
      chk("mr_post_if_rvalid", {31'd0, if_resp_valid}, 32'd0);

      // Idle bus.
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("idle_mem_en_%0d", i), {31'd0, mem_enable}, 32'd0);
         chk($sformatf("idle_rvalid_%0d", i), {30'd0, if_resp_valid, dm_resp_valid}, 32'd0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
